output_vc_credit_alloc: RTL and testbench
=========================================

# output_vc_credit_alloc

Sender-side credit tracker and VC selector for one output port; it sits directly upstream of the downstream router's input-port VC buffers. It holds one credit counter per downstream VC, initialised to the downstream VC depth. It grants a send on a round-robin-chosen VC that has credit and is permitted by the requester's mask. It restores credits from the returned `lcrd_v`/`lcrd_id` stream.

## Interface
- `VC_NUM`, 4: number of downstream VCs.
- `VC_NUM_IDX_W`, `VC_NUM>1 ? $clog2(VC_NUM) : 1`: VC index width.
- `VC_DEPTH`, 2: credits per VC at reset; must equal the downstream VC depth.
- `VC_ID_NUM_MAX_W`, package constant: width of the returned credit id.
- `CNT_W`, `$clog2(VC_DEPTH+1)`: counter width.

Ports:
- `clk`  in  1  clock. One clock domain only.
- `rst`  in  1  reset. Synchronous, active-high.
- `send_req_i`  in  1  the upstream switch stage has a flit to send on this port this cycle.
- `send_vc_mask_i`  in  VC_NUM  VCs this flit may use (QoS/class restriction).
- `send_gnt_o`  out  1  the flit may leave this cycle; one credit is consumed.
- `send_vc_id_o`  out  VC_NUM_IDX_W  VC assigned to the granted flit; drives the flit's `vc_id`.
- `lcrd_v_i`  in  1  credit return from downstream.
- `lcrd_id_i`  in  VC_ID_NUM_MAX_W  VC of the returned credit; only the low `VC_NUM_IDX_W` bits are used.
- `vc_credit_avail_o`  out  VC_NUM  bit i is high when count[i] != 0.
- `vc_credit_cnt_o`  out  VC_NUM*CNT_W  packed counters, for debug and performance monitoring.
- `err_underflow_o`  out  1  sticky: a grant was made with count 0. Unreachable by design; used as a checker.
- `err_overflow_o`  out  1  sticky: a credit was returned to a VC already at `VC_DEPTH`.

## Operation
- State: `cnt[VC_NUM]` (CNT_W each), round-robin pointer `rr_ptr` (VC_NUM_IDX_W), and two sticky error flags.
- Eligible set is `elig = send_vc_mask_i & vc_credit_avail_o`. It uses registered counts only, so a credit returned this cycle is not usable until the next cycle.
- Grant: `send_gnt_o = send_req_i & |elig & ~rst`.
- `send_vc_id_o` is the first set bit of `elig`, searching upward from `rr_ptr` with wrap (VC_NUM-1 → 0).
- `send_vc_id_o` is 0 when there is no grant.
- On a grant, the next `rr_ptr` is the granted id + 1, wrapping from VC_NUM-1 to 0. With no grant, `rr_ptr` holds.
- Counter update per VC i, at the clock edge:
  - `dec = send_gnt_o && send_vc_id_o==i`
  - `inc = lcrd_v_i && lcrd_id_i[VC_NUM_IDX_W-1:0]==i`
  - inc && dec: count unchanged (net 0).
  - dec only: count-1.
  - inc only: count+1, unless count==VC_DEPTH. In that case the count holds and `err_overflow_o` sets.
- Underflow is impossible by construction. If an implementation bug causes dec at 0, the count holds at 0 and `err_underflow_o` sets.
- A return whose `lcrd_id_i` is ≥ VC_NUM is ignored and sets `err_overflow_o`.
- At most one grant and one return per cycle.
- Error flags are cleared only by `rst`.

## Timing
- Grant path is combinational from `send_req_i`/`send_vc_mask_i` to `send_gnt_o`/`send_vc_id_o`, in the same cycle.
- Counter and pointer effects appear one cycle after the triggering edge.
- Credit return to reuse: a credit presented in cycle N is grantable in cycle N+1.
- Reset, while `rst` is high:
  - `cnt[i]=VC_DEPTH` for all i.
  - `rr_ptr=0`.
  - Error flags 0.
  - `send_gnt_o=0`.
  - `send_vc_id_o=0`.
  - `vc_credit_avail_o` reads all-ones from the first cycle after reset.
- Reset mid-traffic: in-flight credits are discarded; counters return to `VC_DEPTH` regardless of outstanding flits. The downstream router must be reset in the same cycle.
- Returns arriving during `rst` are ignored.
- No back-pressure exists apart from credits. `send_req_i` may drop or change mask freely; grants carry no state beyond the cycle.

## Test plan
- Reset, then `send_req_i=1`, mask 4'b1111, held for 8 cycles, no returns (VC_NUM=4, VC_DEPTH=2):
  - grants on VCs 0,1,2,3,0,1,2,3;
  - cycle 9 `send_gnt_o=0`;
  - all counts 0, `vc_credit_avail_o=4'b0000`.
- Drain VC2 to 0, then mask 4'b0100 with `lcrd_v_i=1`, id=2 in cycle N:
  - no grant in cycle N;
  - grant on VC2 in N+1;
  - cnt[2] goes 0→1→0.
- VC1 count 1; in the same cycle grant VC1 and return id 1:
  - cnt[1] stays 1;
  - no error flag.
- All counts at 2; return id 3:
  - cnt[3] stays 2;
  - `err_overflow_o=1` and stays set until `rst`.
- `rr_ptr`=3, mask 4'b0011, all VCs with credit:
  - grant VC0 (wrap);
  - next `rr_ptr`=1.
- Assert `rst` for 1 cycle with counts {0,1,2,0} and errors set:
  - next cycle all counts 2, flags 0, `rr_ptr`=0;
  - a request with mask 4'b1000 grants VC3.

Source files
------------

// File: rtl/output_vc_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : output_vc_credit_alloc
//  Description : Sender-side per-VC credit counters with a round-robin VC
//                selector for one output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_vc_credit_alloc #(
    parameter int VC_NUM          = 4,
    parameter int VC_NUM_IDX_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int VC_DEPTH        = 2,
    parameter int VC_ID_NUM_MAX_W = 4,
    parameter int CNT_W           = $clog2(VC_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      send_req_i,
    input  logic [VC_NUM-1:0]         send_vc_mask_i,
    output logic                      send_gnt_o,
    output logic [VC_NUM_IDX_W-1:0]   send_vc_id_o,
    input  logic                      lcrd_v_i,
    input  logic [VC_ID_NUM_MAX_W-1:0] lcrd_id_i,
    output logic [VC_NUM-1:0]         vc_credit_avail_o,
    output logic [VC_NUM*CNT_W-1:0]   vc_credit_cnt_o,
    output logic                      err_underflow_o,
    output logic                      err_overflow_o
);

    localparam logic [CNT_W-1:0] c_vc_depth = CNT_W'(VC_DEPTH);

    logic [VC_NUM-1:0][CNT_W-1:0] r_cnt;
    logic [VC_NUM_IDX_W-1:0]      r_rr_ptr;
    logic                         r_err_underflow;
    logic                         r_err_overflow;

    logic [VC_NUM-1:0]            w_avail;
    logic [VC_NUM-1:0]            w_elig;
    logic [VC_NUM-1:0]            w_dec;
    logic [VC_NUM-1:0]            w_inc;
    logic [VC_NUM-1:0]            w_unf;
    logic [VC_NUM-1:0]            w_ovf;
    logic                         w_found;
    logic [VC_NUM_IDX_W-1:0]      w_sel;
    logic [VC_NUM_IDX_W-1:0]      w_ret_idx;
    logic                         w_ret_oob;
    logic                         w_gnt;

    assign w_elig    = send_vc_mask_i & w_avail;
    assign w_gnt     = send_req_i & (|w_elig) & ~rst;
    assign w_ret_idx = lcrd_id_i[VC_NUM_IDX_W-1:0];
    assign w_ret_oob = int'(lcrd_id_i) >= VC_NUM;

    // Round-robin search: first eligible VC at or above the pointer, with wrap.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < VC_NUM; k++) begin
            idx = (int'(r_rr_ptr) + k) % VC_NUM;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_sel   = VC_NUM_IDX_W'(idx);
            end
        end
    end

    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
        assign w_avail[gi] = (r_cnt[gi] != '0);
        assign w_dec[gi]   = w_gnt && (w_sel == VC_NUM_IDX_W'(gi));
        assign w_inc[gi]   = lcrd_v_i && !rst && !w_ret_oob && (w_ret_idx == VC_NUM_IDX_W'(gi));
        assign w_unf[gi]   = w_dec[gi] && !w_inc[gi] && (r_cnt[gi] == '0);
        assign w_ovf[gi]   = w_inc[gi] && !w_dec[gi] && (r_cnt[gi] == c_vc_depth);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VC_NUM; i++) begin
                r_cnt[i] <= c_vc_depth;
            end
            r_rr_ptr        <= '0;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
        end else begin
            // Simultaneous grant and return on the same VC cancel out.
            for (int i = 0; i < VC_NUM; i++) begin
                if (w_dec[i] && !w_inc[i] && !w_unf[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end else if (w_inc[i] && !w_dec[i] && !w_ovf[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            if (w_gnt) begin
                r_rr_ptr <= (w_sel == VC_NUM_IDX_W'(VC_NUM - 1)) ? '0 : w_sel + VC_NUM_IDX_W'(1);
            end
            if (|w_unf) begin
                r_err_underflow <= 1'b1;
            end
            if ((|w_ovf) || (lcrd_v_i && w_ret_oob)) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign send_gnt_o        = w_gnt;
    assign send_vc_id_o      = w_gnt ? w_sel : '0;
    assign vc_credit_avail_o = w_avail;
    assign vc_credit_cnt_o   = r_cnt;
    assign err_underflow_o   = r_err_underflow;
    assign err_overflow_o    = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_vc_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_vc_credit_alloc
//  Description : Directed self-checking bench for output_vc_credit_alloc.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_vc_credit_alloc;

    localparam int VC_NUM          = 4;
    localparam int VC_NUM_IDX_W    = 2;
    localparam int VC_DEPTH        = 2;
    localparam int VC_ID_NUM_MAX_W = 4;
    localparam int CNT_W           = 2;

    logic                        clk;
    logic                        rst;
    logic                        send_req_i;
    logic [VC_NUM-1:0]           send_vc_mask_i;
    logic                        send_gnt_o;
    logic [VC_NUM_IDX_W-1:0]     send_vc_id_o;
    logic                        lcrd_v_i;
    logic [VC_ID_NUM_MAX_W-1:0]  lcrd_id_i;
    logic [VC_NUM-1:0]           vc_credit_avail_o;
    logic [VC_NUM*CNT_W-1:0]     vc_credit_cnt_o;
    logic                        err_underflow_o;
    logic                        err_overflow_o;

    int n_checks;
    int n_errors;

    output_vc_credit_alloc #(
        .VC_NUM          (VC_NUM),
        .VC_NUM_IDX_W    (VC_NUM_IDX_W),
        .VC_DEPTH        (VC_DEPTH),
        .VC_ID_NUM_MAX_W (VC_ID_NUM_MAX_W),
        .CNT_W           (CNT_W)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .send_req_i        (send_req_i),
        .send_vc_mask_i    (send_vc_mask_i),
        .send_gnt_o        (send_gnt_o),
        .send_vc_id_o      (send_vc_id_o),
        .lcrd_v_i          (lcrd_v_i),
        .lcrd_id_i         (lcrd_id_i),
        .vc_credit_avail_o (vc_credit_avail_o),
        .vc_credit_cnt_o   (vc_credit_cnt_o),
        .err_underflow_o   (err_underflow_o),
        .err_overflow_o    (err_overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [3:0] mask, input logic lv, input logic [3:0] lid);
        send_req_i     = req;
        send_vc_mask_i = mask;
        lcrd_v_i       = lv;
        lcrd_id_i      = lid;
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(vc_credit_cnt_o[i*CNT_W +: CNT_W]);
    endfunction

    task automatic check_cnts(input string tag, input logic [1:0] c0, input logic [1:0] c1,
                              input logic [1:0] c2, input logic [1:0] c3);
        check({tag, "_c0"}, cnt_of(0), 32'(c0));
        check({tag, "_c1"}, cnt_of(1), 32'(c1));
        check({tag, "_c2"}, cnt_of(2), 32'(c2));
        check({tag, "_c3"}, cnt_of(3), 32'(c3));
    endtask

    task automatic grant_one(input string tag, input logic [3:0] mask, input logic [1:0] exp_id);
        drive(1'b1, mask, 1'b0, 4'd0);
        #1;
        check({tag, "_gnt"}, 32'(send_gnt_o), 32'd1);
        check({tag, "_id"}, 32'(send_vc_id_o), 32'(exp_id));
        tick();
    endtask

    task automatic ret(input logic [3:0] id);
        drive(1'b0, 4'b0000, 1'b1, id);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        drive(1'b1, 4'b1111, 1'b1, 4'd0);
        tick();
        tick();
        #1;
        check("rst_gnt", 32'(send_gnt_o), 32'd0);
        check("rst_vcid", 32'(send_vc_id_o), 32'd0);

        rst = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 4'd0);
        tick();
        check_cnts("post_rst", 2'd2, 2'd2, 2'd2, 2'd2);
        check("post_rst_avail", 32'(vc_credit_avail_o), 32'hf);
        check("post_rst_ovf", 32'(err_overflow_o), 32'd0);
        check("post_rst_unf", 32'(err_underflow_o), 32'd0);

        // Eight back-to-back grants drain every VC in round-robin order.
        for (int k = 0; k < 8; k++) begin
            grant_one("rr8", 4'b1111, 2'(k % 4));
        end
        drive(1'b1, 4'b1111, 1'b0, 4'd0);
        #1;
        check("drain_gnt", 32'(send_gnt_o), 32'd0);
        check("drain_vcid", 32'(send_vc_id_o), 32'd0);
        check("drain_avail", 32'(vc_credit_avail_o), 32'h0);
        check_cnts("drain", 2'd0, 2'd0, 2'd0, 2'd0);

        // A credit returned in cycle N is grantable only in N+1.
        drive(1'b1, 4'b0100, 1'b1, 4'd2);
        #1;
        check("ret_n_gnt", 32'(send_gnt_o), 32'd0);
        tick();
        drive(1'b1, 4'b0100, 1'b0, 4'd0);
        #1;
        check("ret_n1_cnt2", cnt_of(2), 32'd1);
        check("ret_n1_gnt", 32'(send_gnt_o), 32'd1);
        check("ret_n1_id", 32'(send_vc_id_o), 32'd2);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0);
        #1;
        check("ret_n2_cnt2", cnt_of(2), 32'd0);

        // Grant and return on VC1 in the same cycle.
        ret(4'd1);
        check("same_pre_cnt1", cnt_of(1), 32'd1);
        drive(1'b1, 4'b0010, 1'b1, 4'd1);
        #1;
        check("same_gnt", 32'(send_gnt_o), 32'd1);
        check("same_id", 32'(send_vc_id_o), 32'd1);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 4'd0);
        #1;
        check("same_cnt1", cnt_of(1), 32'd1);
        check("same_ovf", 32'(err_overflow_o), 32'd0);
        check("same_unf", 32'(err_underflow_o), 32'd0);

        // Pointer wrap: set rr_ptr to 3 with every VC holding credit.
        ret(4'd0);
        ret(4'd0);
        ret(4'd2);
        ret(4'd3);
        check_cnts("wrap_pre", 2'd2, 2'd1, 2'd1, 2'd1);
        grant_one("wrap_set3", 4'b0100, 2'd2);
        ret(4'd2);
        grant_one("wrap_vc0", 4'b0011, 2'd0);
        grant_one("wrap_ptr1", 4'b1111, 2'd1);
        check_cnts("wrap_post", 2'd1, 2'd0, 2'd1, 2'd1);

        // Overflow: return to a VC already at full depth.
        ret(4'd0);
        ret(4'd1);
        ret(4'd1);
        ret(4'd2);
        ret(4'd3);
        check_cnts("ovf_pre", 2'd2, 2'd2, 2'd2, 2'd2);
        check("ovf_pre_flag", 32'(err_overflow_o), 32'd0);
        ret(4'd3);
        drive(1'b0, 4'b0000, 1'b0, 4'd0);
        check("ovf_cnt3", cnt_of(3), 32'd2);
        check("ovf_flag", 32'(err_overflow_o), 32'd1);
        tick();
        tick();
        check("ovf_sticky", 32'(err_overflow_o), 32'd1);
        check("ovf_unf", 32'(err_underflow_o), 32'd0);

        // Build counts {0,1,2,0} with rr_ptr left at 2, then reset.
        grant_one("pre_rst_a", 4'b1000, 2'd3);
        grant_one("pre_rst_b", 4'b1000, 2'd3);
        grant_one("pre_rst_c", 4'b0001, 2'd0);
        grant_one("pre_rst_d", 4'b0001, 2'd0);
        grant_one("pre_rst_e", 4'b0010, 2'd1);
        check_cnts("pre_rst", 2'd0, 2'd1, 2'd2, 2'd0);
        rst = 1'b1;
        drive(1'b1, 4'b1000, 1'b1, 4'd0);
        #1;
        check("mid_rst_gnt", 32'(send_gnt_o), 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 4'd0);
        #1;
        check_cnts("mid_rst", 2'd2, 2'd2, 2'd2, 2'd2);
        check("mid_rst_ovf", 32'(err_overflow_o), 32'd0);
        check("mid_rst_unf", 32'(err_underflow_o), 32'd0);
        grant_one("mid_rst_ptr0", 4'b1111, 2'd0);
        grant_one("mid_rst_vc3", 4'b1000, 2'd3);

        // Out-of-range return id is ignored but flagged.
        ret(4'd4);
        check("oob_cnt0", cnt_of(0), 32'd1);
        check("oob_flag", 32'(err_overflow_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
